// File: rtl/div_sched.sv
// div_sched: multi-cycle DIV/DIVU scheduler driving the HI/LO write path.
// Radix-2 restoring divider, pipeline stall and one-shot HI/LO strobe.
module div_sched #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_req,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               flush,
  output logic               stall_req,
  output logic               busy,
  output logic               hilo_write,
  output logic [2*WIDTH-1:0] hilo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             wr_q;

  logic             accept;
  logic             div_zero;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] fix_r;
  logic [WIDTH-1:0] fix_q;

  assign accept   = (state == IDLE) & div_req & ~flush;
  assign div_zero = (opb == '0);

  // Operand sign capture; unsigned mode treats both as positive.
  assign sa    = div_signed & opa[WIDTH-1];
  assign sb    = div_signed & opb[WIDTH-1];
  assign abs_a = sa ? -opa : opa;
  assign abs_b = sb ? -opb : opb;

  // One restoring step: shift next dividend bit in, keep difference if non-negative.
  assign trial  = {rem, quo[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];
  assign step_r = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_q = {quo[WIDTH-2:0], ge};

  // Sign correction applied to the final step so hilo is ready in DONE.
  assign fix_q = neg_q ? -step_q : step_q;
  assign fix_r = neg_r ? -step_r : step_r;

  assign stall_req  = accept | ((state == BUSY) & ~flush);
  assign busy       = (state != IDLE);
  assign hilo_write = wr_q & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; flush wins over everything including accept.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (div_req) state_nx = div_zero ? DONE : BUSY;
        BUSY: if (cnt == LAST) state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Divider datapath and registered HI/LO result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      wr_q  <= 1'b0;
      hilo  <= '0;
    end else begin
      wr_q <= 1'b0;
      if (accept) begin
        rem   <= '0;
        quo   <= abs_a;
        dvs   <= abs_b;
        cnt   <= '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        if (div_zero) begin
          hilo <= {opa, {WIDTH{1'b1}}};
          wr_q <= 1'b1;
        end
      end else if ((state == BUSY) && !flush) begin
        rem <= step_r;
        quo <= step_q;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          hilo <= {fix_r, fix_q};
          wr_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed and random divides against an arithmetic model.
// Tracks latency, stall, strobe count, flush and reset behaviour.
module tb_div_sched;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_req;
  logic           div_signed;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           flush;
  logic           stall_req;
  logic           busy;
  logic           hilo_write;
  logic [2*W-1:0] hilo;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int exp_wr = 0;

  div_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_req    (div_req),
    .div_signed (div_signed),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .hilo_write (hilo_write),
    .hilo       (hilo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (hilo_write === 1'b1) n_wr++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide and follow it to its strobe; div_req stays high after.
  task automatic do_div(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic s);
    logic [63:0] exp;
    bit got;
    int lat;
    exp = model(a, b, s);
    @(negedge clk);
    div_req = 1'b1; div_signed = s; opa = a; opb = b; flush = 1'b0;
    #1;
    chk("stall_accept", stall_req, 1);
    got = 0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      opa = $urandom;
      opb = $urandom;
      #1;
      if (hilo_write) begin
        got = 1;
        lat = i;
        chk("latency", lat, (b == 0) ? 1 : W + 1);
        chk("hilo", hilo, exp);
        chk("stall_done", stall_req, 0);
      end else if (!stall_req || !busy) begin
        chk("stall_busy", {stall_req, busy}, 2'b11);
      end
    end
    if (!got) chk("timeout", 0, 1);
    exp_wr++;
  endtask

  task automatic go_idle();
    @(negedge clk);
    div_req = 1'b0; flush = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_wr", hilo_write, 0);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;
    rst = 1'b1; div_req = 1'b0; div_signed = 1'b0;
    opa = '0; opb = '0; flush = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr", hilo_write, 0);
    chk("rst_hilo", hilo, 0);
    chk("rst_stall", stall_req, 0);

    do_div(32'd100, 32'd7, 1'b0);
    go_idle();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'd5, 32'd0, 1'b0);
    go_idle();

    // Flush in BUSY cycle 10.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; opa = 32'd1000; opb = 32'd3;
    wait_cyc(10);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall_req, 0);
    chk("flush_wr", hilo_write, 0);
    go_idle();
    wait_cyc(40);
    chk("flush_nowrite", n_wr, exp_wr);
    do_div(32'd9, 32'd3, 1'b0);
    go_idle();

    // Flush during DONE of a divide-by-zero.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b1; opa = 32'd77; opb = 32'd0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flushdone_wr", hilo_write, 0);
    chk("flushdone_stall", stall_req, 0);
    go_idle();
    chk("flushdone_cnt", n_wr, exp_wr);

    // Back-to-back with div_req held.
    do_div(32'd20, 32'd6, 1'b0);
    do_div(32'd50, 32'd5, 1'b0);
    go_idle();
    wait_cyc(2);
    chk("b2b_cnt", n_wr, exp_wr);

    // Reset at BUSY cycle 20.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; opa = 32'd12345; opb = 32'd11;
    wait_cyc(20);
    rst = 1'b1;
    div_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_hilo", hilo, 0);
    chk("rstmid_wr", hilo_write, 0);
    wait_cyc(40);
    chk("rstmid_cnt", n_wr, exp_wr);

    // Request together with flush in IDLE is ignored.
    @(negedge clk);
    div_req = 1'b1; flush = 1'b1; opa = 32'd8; opb = 32'd2;
    #1;
    chk("reqflush_stall", stall_req, 0);
    go_idle();

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_div(ra, rb, rs);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
    wait_cyc(2);
    chk("final_cnt", n_wr, exp_wr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Multi-cycle divide scheduler that owns the HI/LO write path for DIV/DIVU.
- Accepts a divide request from the EX stage and stalls the pipeline while a radix-2 restoring divider iterates.
- Produces one HI/LO write strobe in the same format the write-back stage forwards: hilo_write plus a 64-bit {HI, LO}.
- Cancels cleanly on an exception flush.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- div_req  in  1  EX holds a valid DIV/DIVU; stays high while stalled.
- div_signed  in  1  1 = DIV (signed), 0 = DIVU; sampled with div_req.
- opa  in  WIDTH  dividend; sampled at accept.
- opb  in  WIDTH  divisor; sampled at accept.
- flush  in  1  exception or eret flush; aborts any divide.
- stall_req  out  1  pipeline stall request (combinational from state and inputs).
- busy  out  1  state != IDLE (registered state decode).
- hilo_write  out  1  one-cycle HI/LO write strobe.
- hilo  out  2*WIDTH  {HI = remainder, LO = quotient}; valid when hilo_write = 1.

Behaviour:
- States: IDLE, BUSY, DONE. Reset gives IDLE, counter 0, hilo_write 0, hilo 0, busy 0.
- IDLE:
  - If div_req & ~flush: latch abs values (signed mode) or raw values (unsigned), plus the sign of opa and sign(opa) XOR sign(opb).
  - If opb == 0, go directly to DONE. Otherwise go to BUSY with counter 0.
- BUSY:
  - Each cycle, shift one dividend bit into the partial remainder and subtract the divisor when the result is non-negative. Counter increments.
  - After WIDTH iterations (counter == WIDTH-1 on the edge), go to DONE.
- DONE:
  - Apply sign correction: quotient negated if the signs differed; remainder takes the dividend's sign.
  - hilo_write = 1 for exactly this cycle.
  - Go unconditionally to IDLE. div_req seen during DONE is the same instruction and must not restart.
- Divide by zero: LO = all ones, HI = opa (raw operand). No iterations are run.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No special path.
- stall_req = (IDLE & div_req & ~flush) | BUSY. It is 0 in DONE so the instruction advances at the end of DONE.
- Latency, normal case: request accepted at cycle 0, BUSY cycles 1..WIDTH, DONE at cycle WIDTH+1, so 33 cycles of stall for WIDTH = 32.
- Latency, divide by zero: DONE at cycle 1, so 1 cycle of stall.
- flush in any state: next state IDLE, stall_req forced 0 that cycle, hilo_write forced 0 that cycle. No partial result is ever written. Flush has priority over accept.
- rst mid-divide: IDLE next edge, no hilo_write.
- Back-to-back divides: a new div_req in the IDLE cycle after DONE is accepted normally. There are no bubble requirements.
- hilo and hilo_write are registered outputs. hilo holds its last value when hilo_write = 0.

Test Plan:
1. DIVU opa=100, opb=7 -> stall_req high for 33 cycles; one hilo_write pulse with hilo = {32'd2, 32'd14}; busy low the following cycle.
2. DIV opa=-7 (0xFFFFFFF9), opb=2 -> hilo = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quo -3); then DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
3. DIV opa=0x80000000, opb=0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU opa=5, opb=0 -> hilo_write one cycle after accept with {0x00000005, 0xFFFFFFFF}.
4. flush asserted on BUSY cycle 10 -> state IDLE next edge, stall_req 0 in the flush cycle, no hilo_write ever; a new request then completes correctly (e.g. 9/3 -> {0, 3}).
5. Two consecutive DIVU (20/6, then 50/5) with div_req held through stalls -> exactly two hilo_write pulses ({2, 3}, then {0, 10}); no extra restart from div_req during DONE.
6. rst pulse at BUSY cycle 20 -> IDLE, outputs zero, no write; div_req together with flush in IDLE -> not accepted, stall_req 0.
